alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential integer ALU: single-cycle ops 0-9 and an iterative shift-add multiply.
// Valid/ready request and result handshakes with a registered result and nonzero flag.
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            nonzero_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_MUL = 4'd10;

  state_t          state_r;
  logic [XLEN-1:0] result_r;
  logic            nonzero_r;
  logic [XLEN-1:0] mcand_r;
  logic [XLEN-1:0] mplier_r;
  logic [XLEN-1:0] acc_r;
  logic [SHW-1:0]  cnt_r;

  logic            in_ready_s;
  logic            accept_s;
  logic [XLEN-1:0] alu_s;
  logic [XLEN-1:0] step_sum_s;
  logic            last_step_s;

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0]      op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] r;
    sh = b[SHW-1:0];
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a + ~b + {{(XLEN-1){1'b0}}, 1'b1};
      4'd2:    r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd3:    r = {{(XLEN-1){1'b0}}, (a < b)};
      4'd4:    r = a ^ b;
      4'd5:    r = a | b;
      4'd6:    r = a & b;
      4'd7:    r = a << sh;
      4'd8:    r = a >> sh;
      4'd9:    r = $unsigned($signed(a) >>> sh);
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  // Handshake decode and one shift-add multiply step
  always_comb begin
    in_ready_s  = 1'b0;
    step_sum_s  = acc_r;
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      DONE:    in_ready_s = out_ready_i;
      default: in_ready_s = 1'b0;
    endcase
    if (mplier_r[0]) begin
      step_sum_s = acc_r + mcand_r;
    end else begin
      step_sum_s = acc_r;
    end
    accept_s    = in_valid_i && in_ready_s;
    last_step_s = (cnt_r == SHW'(XLEN - 1));
    alu_s       = alu_f(op_i, operand_a_i, operand_b_i);
  end

  // FSM, operand capture, multiply iteration and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      result_r  <= {XLEN{1'b0}};
      nonzero_r <= 1'b0;
      mcand_r   <= {XLEN{1'b0}};
      mplier_r  <= {XLEN{1'b0}};
      acc_r     <= {XLEN{1'b0}};
      cnt_r     <= {SHW{1'b0}};
    end else if (accept_s) begin
      // Same path serves IDLE accepts and the zero-bubble handoff out of DONE
      if (op_i == OP_MUL) begin
        state_r  <= BUSY;
        mcand_r  <= operand_a_i;
        mplier_r <= operand_b_i;
        acc_r    <= {XLEN{1'b0}};
        cnt_r    <= {SHW{1'b0}};
      end else begin
        state_r   <= DONE;
        result_r  <= alu_s;
        nonzero_r <= |alu_s;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        BUSY: begin
          acc_r    <= step_sum_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          if (last_step_s) begin
            state_r   <= DONE;
            result_r  <= step_sum_s;
            nonzero_r <= |step_sum_s;
            cnt_r     <= {SHW{1'b0}};
          end else begin
            cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = (state_r == DONE);
  assign busy_o      = (state_r == BUSY);
  assign result_o    = result_r;
  assign nonzero_o   = nonzero_r;

endmodule
